// File: rtl/snn_cdc_pkg.sv
// Shared definitions for the asynchronous edge capture / event arbiter block:
// edge-mode encodings, parameter bounds and the edge qualification helper.
package snn_cdc_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_e;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } warm_state_e;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 32;
  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;

  // True when the transition prev -> cur matches the selected edge mode.
  function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic prev);
    logic hit;
    hit = 1'b0;
    case (edge_mode_e'(mode))
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_BOTH: hit = cur ^ prev;
      EDGE_NONE: hit = 1'b0;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_edge_ch.sv
// One event channel: input synchronizer, history flop, edge qualification and
// a saturating pending-event counter with a sticky overflow flag.
module sync_edge_ch
  import snn_cdc_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       async_in,
  input  logic       en,
  input  logic [1:0] edge_mode,
  input  logic       clr,
  input  logic       grant,
  output logic       pending,
  output logic       ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   hist_p1;
  logic [CNT_W-1:0]       cnt_p2;
  logic                   qual;

  // Stage 0/1: synchronizer chain and history flop; clr leaves them running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_in};
      hist_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign qual = en && edge_hit(edge_mode, sync_p0[SYNC_STAGES-1], hist_p1);

  // Stage 2: pending counter, updated on the same edge as the history flop.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_p2 <= '0;
      ovf    <= 1'b0;
    end else begin
      case ({qual, grant})
        2'b10: begin
          if (cnt_p2 == CNT_MAX) ovf <= 1'b1;
          else                   cnt_p2 <= cnt_p2 + CNT_W'(1);
        end
        2'b01:   cnt_p2 <= cnt_p2 - CNT_W'(1);
        default: cnt_p2 <= cnt_p2;
      endcase
    end
  end

  assign pending = |cnt_p2;

endmodule

// File: rtl/sync_edge_arbiter.sv
// Captures edges on NUM_CH asynchronous inputs into per-channel pending counters
// and presents them one at a time through a round-robin valid/ready event port.
module sync_edge_arbiter
  import snn_cdc_pkg::*;
#(
  parameter int  NUM_CH      = 8,
  parameter int  SYNC_STAGES = 3,
  parameter int  CNT_W       = 4,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] async_in,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [1:0]        edge_mode,
  input  logic              clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic [NUM_CH-1:0] ch_ovf,
  output logic              busy
);

  localparam int WARM_N = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM_N);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("sync_edge_arbiter: NUM_CH out of range");
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("sync_edge_arbiter: SYNC_STAGES out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("sync_edge_arbiter: CNT_W must be at least 1");
  end

  warm_state_e        state, state_nxt;
  logic [WARM_W-1:0]  warm_cnt, warm_cnt_nxt;
  logic               qual_en;

  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  grant;
  logic [CH_W-1:0]    ptr;
  logic [CH_W-1:0]    gnt_idx, hi_idx, lo_idx, nxt_ptr;
  logic               gnt_found, hi_found, lo_found;
  logic               can_load, do_grant;

  // Warm-up: the synchronizers start from zero, so an input already high at
  // reset release would look like a rising edge; hold off qualification until
  // the history flop has caught up with the synchronized input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_WARM;
      warm_cnt <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    qual_en      = 1'b0;
    case (state)
      ST_WARM: begin
        warm_cnt_nxt = warm_cnt + WARM_W'(1);
        if (warm_cnt == WARM_W'(WARM_N - 1)) state_nxt = ST_RUN;
      end
      ST_RUN:  qual_en = 1'b1;
      default: state_nxt = ST_WARM;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_edge_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .async_in  (async_in[i]),
      .en        (ch_en[i] && qual_en),
      .edge_mode (edge_mode),
      .clr       (clr),
      .grant     (grant[i]),
      .pending   (pending[i]),
      .ovf       (ch_ovf[i])
    );
  end

  // Round-robin pick: lowest pending index at or above ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!hi_found && pending[i] && (CH_W'(i) >= ptr)) begin
        hi_found = 1'b1;
        hi_idx   = CH_W'(i);
      end
      if (!lo_found && pending[i]) begin
        lo_found = 1'b1;
        lo_idx   = CH_W'(i);
      end
    end
    gnt_found = lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign nxt_ptr  = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
  assign can_load = !evt_valid || evt_ready;
  assign do_grant = can_load && gnt_found && !clr;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant[i] = do_grant && (gnt_idx == CH_W'(i));
    end
  end

  // Output register: loads on grant, holds while stalled, clr drops it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      ptr       <= '0;
    end else if (clr) begin
      evt_valid <= 1'b0;
    end else if (can_load) begin
      evt_valid <= gnt_found;
      if (gnt_found) begin
        evt_ch <= gnt_idx;
        ptr    <= nxt_ptr;
      end
    end
  end

  assign busy = (|pending) || evt_valid;

endmodule

// File: tb/tb_sync_edge_arbiter.sv
// Bench for sync_edge_arbiter: scoreboard of expected event channels fed by a
// vector table and hand-written corner-case sequences.
module tb_sync_edge_arbiter;

  localparam int NUM_CH      = 8;
  localparam int SYNC_STAGES = 3;
  localparam int CNT_W       = 4;
  localparam int CH_W        = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] async_in;
  logic [NUM_CH-1:0] ch_en;
  logic [1:0]        edge_mode;
  logic              clr;
  logic              evt_valid;
  logic              evt_ready;
  logic [CH_W-1:0]   evt_ch;
  logic [NUM_CH-1:0] ch_ovf;
  logic              busy;

  always #5 clk = ~clk;

  sync_edge_arbiter #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (async_in),
    .ch_en     (ch_en),
    .edge_mode (edge_mode),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .ch_ovf    (ch_ovf),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int exp_ch;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] en;
    logic [7:0] ain;
    int         n;
    int         exp [4];
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int idx, input logic [1:0] mode, input logic [7:0] en,
                         input logic [7:0] ain, input int n,
                         input int e0, input int e1, input int e2, input int e3);
    vt[idx].mode   = mode;
    vt[idx].en     = en;
    vt[idx].ain    = ain;
    vt[idx].n      = n;
    vt[idx].exp[0] = e0;
    vt[idx].exp[1] = e1;
    vt[idx].exp[2] = e2;
    vt[idx].exp[3] = e3;
  endtask

  // Every accepted handshake must match the oldest expected channel.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", 32'(evt_ch), 32'hFFFF_FFFF);
      end else begin
        exp_ch = exp_q.pop_front();
        chk("evt_ch", 32'(evt_ch), 32'(exp_ch));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // Round-robin pointer is 4 when the table starts (last grant was ch 3).
    set_vec(0, 2'b00, 8'hFF, 8'h81, 2, 7, 0, 0, 0);
    set_vec(1, 2'b01, 8'hFF, 8'h01, 1, 7, 0, 0, 0);
    set_vec(2, 2'b10, 8'hFF, 8'h19, 2, 3, 4, 0, 0);
    set_vec(3, 2'b11, 8'hFF, 8'hE6, 0, 0, 0, 0, 0);
    set_vec(4, 2'b10, 8'h0F, 8'h19, 4, 0, 1, 2, 3);
    set_vec(5, 2'b00, 8'hFF, 8'h39, 1, 5, 0, 0, 0);
    set_vec(6, 2'b01, 8'h20, 8'h00, 1, 5, 0, 0, 0);

    rst_n     = 1'b0;
    async_in  = '1;
    ch_en     = '1;
    edge_mode = 2'b00;
    clr       = 1'b0;
    evt_ready = 1'b1;
    tick(5);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_ch",    32'(evt_ch),    0);
    chk("rst_ovf",   32'(ch_ovf),    0);
    chk("rst_busy",  32'(busy),      0);

    // Inputs high across reset release must not produce events.
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      chk("warm_valid", 32'(evt_valid), 0);
      chk("warm_busy",  32'(busy),      0);
    end
    async_in = '0;
    tick(10);

    // Simultaneous edges on 1,5,6 drain on consecutive cycles.
    exp_q.push_back(1); exp_q.push_back(5); exp_q.push_back(6);
    async_in = 8'h62;
    w = 0;
    while (!evt_valid && w < 12) begin tick(1); w++; end
    chk("rr_first_valid", 32'(evt_valid), 1);
    chk("rr_first_ch",    32'(evt_ch),    1);
    tick(1);
    chk("rr_second_valid", 32'(evt_valid), 1);
    chk("rr_second_ch",    32'(evt_ch),    5);
    tick(1);
    chk("rr_third_valid", 32'(evt_valid), 1);
    chk("rr_third_ch",    32'(evt_ch),    6);
    tick(1);
    chk("rr_idle", 32'(evt_valid), 0);
    async_in = '0;
    tick(10);
    // A lone grant on ch 1 moves the pointer to 2, so 1 and 2 together give 2 then 1.
    exp_q.push_back(1);
    async_in = 8'h02;
    tick(10);
    async_in = '0;
    tick(10);
    exp_q.push_back(2); exp_q.push_back(1);
    async_in = 8'h06;
    tick(10);
    async_in = '0;
    tick(10);
    chk("rr_drained", 32'(exp_q.size()), 0);

    // Latency from input change to evt_valid is SYNC_STAGES+2 edges.
    exp_q.push_back(3);
    async_in[3] = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      tick(1);
      chk("lat_early_valid", 32'(evt_valid), 0);
    end
    tick(1);
    chk("lat_valid", 32'(evt_valid), 1);
    chk("lat_ch",    32'(evt_ch),    3);
    tick(1);
    chk("lat_one_cycle", 32'(evt_valid), 0);
    async_in[3] = 1'b0;
    tick(10);

    for (int v = 0; v < 7; v++) begin
      ch_en     = vt[v].en;
      edge_mode = vt[v].mode;
      tick(1);
      for (int j = 0; j < vt[v].n; j++) exp_q.push_back(vt[v].exp[j]);
      async_in = vt[v].ain;
      tick(15);
      chk($sformatf("vec%0d_drained", v), 32'(exp_q.size()), 0);
      chk($sformatf("vec%0d_busy", v),    32'(busy),         0);
    end

    // Disabled channel ignores toggles; re-enabled with falling mode gives one event.
    ch_en     = 8'hEF;
    edge_mode = 2'b10;
    tick(1);
    async_in[4] = 1'b1; tick(6);
    async_in[4] = 1'b0; tick(6);
    async_in[4] = 1'b1; tick(10);
    chk("dis_busy", 32'(busy), 0);
    ch_en     = 8'hFF;
    edge_mode = 2'b01;
    tick(1);
    exp_q.push_back(4);
    async_in[4] = 1'b0;
    tick(15);
    chk("en_drained", 32'(exp_q.size()), 0);

    // Saturation: the first edge sits in the output register, the counter
    // fills to 15, the last four edges are dropped and flag overflow.
    edge_mode = 2'b10;
    evt_ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      async_in[0] = ~async_in[0];
      tick(6);
    end
    tick(10);
    chk("sat_ovf",   32'(ch_ovf),    32'h01);
    chk("sat_valid", 32'(evt_valid), 1);
    chk("sat_ch",    32'(evt_ch),    0);
    chk("sat_busy",  32'(busy),      1);
    for (int t = 0; t < 16; t++) exp_q.push_back(0);
    evt_ready = 1'b1;
    tick(30);
    chk("sat_drained",    32'(exp_q.size()), 0);
    chk("sat_idle_valid", 32'(evt_valid),    0);
    chk("sat_ovf_sticky", 32'(ch_ovf),       32'h01);

    // clr discards pending events and overflow flags in one cycle.
    evt_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      async_in[2] = ~async_in[2];
      tick(6);
    end
    tick(10);
    chk("clr_pre_valid", 32'(evt_valid), 1);
    chk("clr_pre_ch",    32'(evt_ch),    2);
    chk("clr_pre_busy",  32'(busy),      1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_valid", 32'(evt_valid), 0);
    chk("clr_busy",  32'(busy),      0);
    chk("clr_ovf",   32'(ch_ovf),    0);
    evt_ready = 1'b1;
    tick(15);
    chk("clr_quiet_busy", 32'(busy), 0);

    // Reset in the middle of a stalled handshake drops everything cleanly.
    evt_ready = 1'b0;
    async_in[6] = 1'b1; tick(6);
    async_in[6] = 1'b0; tick(10);
    chk("mid_pre_valid", 32'(evt_valid), 1);
    chk("mid_pre_ch",    32'(evt_ch),    6);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_busy",  32'(busy),      0);
    chk("mid_rst_ch",    32'(evt_ch),    0);
    chk("mid_rst_ovf",   32'(ch_ovf),    0);
    for (int c = 0; c < 2; c++) begin
      tick(1);
      chk("mid_rst_hold_valid", 32'(evt_valid), 0);
    end
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    tick(40);
    chk("mid_after_busy",  32'(busy),      0);
    chk("mid_after_valid", 32'(evt_valid), 0);

    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
